digit_scan_display: RTL and testbench
=====================================

Name: digit_scan_display

Overview:
Time-multiplexed 7-segment driver for the intersection countdown display. It consumes the two-digit code and flicker flag produced by the light-time digit translator, one pair per direction (channel 0 and channel 1). It scans four common-anode digits, decodes nibbles to glyphs and blanks a channel's digits in a blink cadence while that channel's flicker flag is set. It sits between the digit translators and the board's digit-enable and segment pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit slot is held (>= GUARD+1)
BLINK_DIV, 12500000, clock cycles per blink half-period (>= 1)
GUARD, 2, cycles at the start of each slot with all digits disabled (anti-ghosting, 0 allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
sec0  input  8  channel 0 code: [7:4] tens nibble (1 or 4'hF = blank), [3:0] ones nibble
flicker0  input  1  channel 0 blink request
sec1  input  8  channel 1 code, same format
flicker1  input  1  channel 1 blink request
an  output  4  digit enables, active low; an[i] drives digit i
seg  output  7  segments {g,f,e,d,c,b,a}, active low
blink_phase  output  1  current blink phase, 1 = blanked half

Behaviour:
- One clock; reset is synchronous and active-low. Reset is sampled only on the rising edge of clk while rst_n=0.
- Reset values:
  - an=4'b1111, seg=7'b1111111, blink_phase=0
  - scan_cnt=0, digit_idx=0, blink_cnt=0
  - snapshot registers: sec0/sec1=8'hFF, flicker0/flicker1=0
- Digit map:
  - digit0 = ch0 ones, digit1 = ch0 tens
  - digit2 = ch1 ones, digit3 = ch1 tens
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, digit_idx increments modulo 4 (3 -> 0).
- Snapshot (tear-free): on the cycle scan_cnt wraps with digit_idx=3, all four inputs are registered. The display shows only snapshot values, so an input change becomes visible at the next frame start.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1.
  - On wrap, blink_phase toggles.
  - Free-running; not reset by flicker changes.
- Glyph decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..14 = dash 0111111 (error indicator)
  - 15 = blank 1111111
- Per-slot output:
  - If scan_cnt < GUARD: an=1111, seg=1111111.
  - Otherwise: an = one-hot-low of digit_idx, and seg = glyph of the selected snapshot nibble.
  - If the channel's snapshot flicker=1 and blink_phase=1, seg=1111111 while an is still driven.
- Latency: an/seg are registered, 1 cycle after the scan_cnt/digit_idx state they reflect.
- Boundaries:
  - Simultaneous scan wrap and blink wrap: both take effect independently in the same cycle.
  - Flicker dropping while blanked: the digits reappear at the next frame snapshot.
  - Reset mid-frame: outputs blank on the next edge and scanning restarts at digit0, slot 0, with the snapshot showing blank until the first frame completes.

Decomposition:
- Shared package (disp_pkg):
  - glyph constants GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_BLANK
  - NIBBLE_BLANK=4'hF, NUM_DIGITS=4
  - digit-index typedef (2 bits)
- Sub-module seg7_decode: combinational, 4-bit nibble -> 7-bit active-low glyph. It is reused by any future display block.

Test Plan:
(all with SCAN_DIV=4, BLINK_DIV=32, GUARD=1)
1. Reset held 3 cycles, then release with sec0=8'h13, sec1=8'hF7, flickers 0 -> an=1111/seg=1111111 through the first frame (8'hFF snapshot). Next frame per slot: an=1110 seg=0110000 ('3'), an=1101 seg=1111001 ('1'), an=1011 seg=1111000 ('7'), an=0111 seg=1111111 (blank tens). an=1111 during cycle 0 of each slot.
2. sec0 changes 8'h13 -> 8'h12 mid-frame -> digit0 keeps showing '3' until the frame wrap, then shows 0100100.
3. flicker1=1, sec1=8'hF4 -> digits 2/3 show '4'/blank for 32 cycles, then all-blank for 32 cycles (blink_phase=1), alternating. Digits 0/1 are unaffected.
4. sec0=8'hFC -> digit0 shows dash 0111111.
5. Assert rst_n=0 for 1 cycle in slot 2 -> next edge an=1111 seg=1111111, blink_phase=0, digit_idx=0. Inputs are re-snapshot only after a full frame.
6. flicker0 drops while blink_phase=1 -> ch0 digits stay blank until the next snapshot, then show normally.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] NIBBLE_BLANK = 4'hF;
    localparam int unsigned NUM_DIGITS  = 4;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment glyph; 10..14 render as a dash.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_DASH;
        case (nibble_i)
            4'd0:         glyph_o = GLYPH_0;
            4'd1:         glyph_o = GLYPH_1;
            4'd2:         glyph_o = GLYPH_2;
            4'd3:         glyph_o = GLYPH_3;
            4'd4:         glyph_o = GLYPH_4;
            4'd5:         glyph_o = GLYPH_5;
            4'd6:         glyph_o = GLYPH_6;
            4'd7:         glyph_o = GLYPH_7;
            4'd8:         glyph_o = GLYPH_8;
            4'd9:         glyph_o = GLYPH_9;
            NIBBLE_BLANK: glyph_o = GLYPH_BLANK;
            default:      glyph_o = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/digit_scan_display.sv
// Four-digit time-multiplexed countdown display with per-channel blink and
// frame-aligned input snapshot so a digit pair never tears mid-scan.
module digit_scan_display
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned GUARD     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sec0,
    input  logic       flicker0,
    input  logic [7:0] sec1,
    input  logic       flicker1,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       blink_phase
);

    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    digit_idx_t        digit_idx_q, digit_idx_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [7:0]        snap_sec0_q, snap_sec0_d;
    logic [7:0]        snap_sec1_q, snap_sec1_d;
    logic              snap_flk0_q, snap_flk0_d;
    logic              snap_flk1_q, snap_flk1_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic       scan_wrap;
    logic       blink_wrap;
    logic       frame_end;
    logic [7:0] sel_sec;
    logic       sel_flk;
    logic [3:0] sel_nibble;
    logic [6:0] sel_glyph;

    seg7_decode u_seg7_decode (
        .nibble_i (sel_nibble),
        .glyph_o  (sel_glyph)
    );

    always_comb begin
        scan_wrap   = (scan_cnt_q == ScanMax);
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        frame_end   = scan_wrap && (digit_idx_q == digit_idx_t'(NUM_DIGITS - 1));

        blink_wrap    = (blink_cnt_q == BlinkMax);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;

        snap_sec0_d = frame_end ? sec0     : snap_sec0_q;
        snap_sec1_d = frame_end ? sec1     : snap_sec1_q;
        snap_flk0_d = frame_end ? flicker0 : snap_flk0_q;
        snap_flk1_d = frame_end ? flicker1 : snap_flk1_q;

        // digit_idx[1] selects the channel, digit_idx[0] selects tens over ones
        sel_sec    = digit_idx_q[1] ? snap_sec1_q : snap_sec0_q;
        sel_flk    = digit_idx_q[1] ? snap_flk1_q : snap_flk0_q;
        sel_nibble = digit_idx_q[0] ? sel_sec[7:4] : sel_sec[3:0];

        an_d  = 4'b1111;
        seg_d = GLYPH_BLANK;
        if (32'(scan_cnt_q) >= GUARD) begin
            an_d = ~(4'b0001 << digit_idx_q);
            if (!(sel_flk && blink_phase_q)) begin
                seg_d = sel_glyph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_sec0_q   <= 8'hFF;
            snap_sec1_q   <= 8'hFF;
            snap_flk0_q   <= 1'b0;
            snap_flk1_q   <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= GLYPH_BLANK;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_sec0_q   <= snap_sec0_d;
            snap_sec1_q   <= snap_sec1_d;
            snap_flk0_q   <= snap_flk0_d;
            snap_flk1_q   <= snap_flk1_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_digit_scan_display.sv
// Bench for digit_scan_display: time-indexed reference model plus directed
// literal checks, followed by randomized inputs and reset pulses.
module tb_digit_scan_display;

    localparam int unsigned SD = 4;
    localparam int unsigned BD = 32;
    localparam int unsigned GD = 1;
    localparam int unsigned FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sec0, sec1;
    logic       flicker0, flicker1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       blink_phase;

    always #5 clk = ~clk;

    digit_scan_display #(
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD),
        .GUARD     (GD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sec0        (sec0),
        .flicker0    (flicker0),
        .sec1        (sec1),
        .flicker1    (flicker1),
        .an          (an),
        .seg         (seg),
        .blink_phase (blink_phase)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    logic [6:0] glyph_tbl [16];
    initial begin
        glyph_tbl[0]  = 7'b1000000; glyph_tbl[1]  = 7'b1111001;
        glyph_tbl[2]  = 7'b0100100; glyph_tbl[3]  = 7'b0110000;
        glyph_tbl[4]  = 7'b0011001; glyph_tbl[5]  = 7'b0010010;
        glyph_tbl[6]  = 7'b0000010; glyph_tbl[7]  = 7'b1111000;
        glyph_tbl[8]  = 7'b0000000; glyph_tbl[9]  = 7'b0010000;
        for (int i = 10; i < 15; i++) glyph_tbl[i] = 7'b0111111;
        glyph_tbl[15] = 7'b1111111;
    end

    // Model: m = cycles since reset; position, digit and blink phase follow
    // from integer division of m. Outputs after an edge reflect state m.
    int         m = 0;
    logic [7:0] msec [2];
    logic       mflk [2];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_ph;
    bit         model_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m = 0;
            msec[0] = 8'hFF; msec[1] = 8'hFF;
            mflk[0] = 1'b0;  mflk[1] = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_ph = 1'b0;
            model_valid = 1;
        end else if (model_valid) begin
            int slot, dig, ch;
            logic [3:0] nib;
            slot = m % SD;
            dig  = (m / SD) % 4;
            ch   = dig / 2;
            nib  = (dig % 2 == 1) ? msec[ch][7:4] : msec[ch][3:0];
            if (slot < GD) begin
                exp_an = 4'hF; exp_seg = 7'h7F;
            end else begin
                exp_an = 4'hF;
                exp_an[dig] = 1'b0;
                exp_seg = (mflk[ch] && ((m / BD) % 2 == 1)) ? 7'h7F : glyph_tbl[nib];
            end
            if (m % FRAME == FRAME - 1) begin
                msec[0] = sec0; msec[1] = sec1;
                mflk[0] = flicker0; mflk[1] = flicker1;
            end
            m++;
            exp_ph = ((m / BD) % 2 == 1);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("an", {4'h0, an}, {4'h0, exp_an});
            check("seg", {1'b0, seg}, {1'b0, exp_seg});
            check("blink_phase", {7'h0, blink_phase}, {7'h0, exp_ph});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        sec0 = 8'h13; sec1 = 8'hF7;
        flicker0 = 1'b0; flicker1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame shows the reset snapshot (all blank)
        step(10);
        check("lit_first_frame_seg", {1'b0, seg}, 8'h7F);
        step(7);
        check("lit_guard_an", {4'h0, an}, 8'h0F);
        step(1);
        check("lit_d0_an", {4'h0, an}, 8'h0E);
        check("lit_d0_seg", {1'b0, seg}, 8'h30);
        sec0 = 8'h12;  // mid-frame change, must not show until next frame
        step(4);
        check("lit_d1_an", {4'h0, an}, 8'h0D);
        check("lit_d1_seg", {1'b0, seg}, 8'h79);
        step(4);
        check("lit_d2_an", {4'h0, an}, 8'h0B);
        check("lit_d2_seg", {1'b0, seg}, 8'h78);
        step(4);
        check("lit_d3_an", {4'h0, an}, 8'h07);
        check("lit_d3_seg", {1'b0, seg}, 8'h7F);
        step(1);
        check("lit_phase0", {7'h0, blink_phase}, 8'h00);
        step(1);
        check("lit_phase1", {7'h0, blink_phase}, 8'h01);
        step(2);
        check("lit_new_d0_seg", {1'b0, seg}, 8'h24);

        // Channel 1 blink
        flicker1 = 1'b1; sec1 = 8'hF4;
        step(100);
        // Dash on error nibble
        sec0 = 8'hFC;
        step(40);

        // Reset pulse in slot 2
        while (((m / SD) % 4) != 2) step(1);
        rst_n = 1'b0;
        step(1);
        check("lit_rst_an", {4'h0, an}, 8'h0F);
        check("lit_rst_seg", {1'b0, seg}, 8'h7F);
        check("lit_rst_phase", {7'h0, blink_phase}, 8'h00);
        rst_n = 1'b1;
        step(20);

        // Flicker0 drops while blanked
        flicker0 = 1'b1; sec0 = 8'h45;
        while (((m / BD) % 2) == 0) step(1);
        step(20);
        flicker0 = 1'b0;
        step(60);

        // Randomized inputs with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                sec0 = 8'($urandom);
                sec1 = 8'($urandom);
                flicker0 = 1'($urandom);
                flicker1 = 1'($urandom);
            end
            if ($urandom_range(399, 0) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end else begin
                step(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
